// File: rtl/wb_arbiter2_pkg.sv
// Shared types and Wishbone widths for the two-master arbiter.
package wb_arbiter2_pkg;

    localparam int unsigned WB_AW = 30;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    // Master-to-slave request payload routed by the grant mux.
    typedef struct packed {
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic             we;
        logic [WB_SW-1:0] sel;
        logic             stb;
        logic             cyc;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter2_timeout.sv
// Counts consecutive un-acked strobe cycles; expire flags the cycle that
// reaches the limit so the arbiter can abort on the following edge.
module wb_timeout #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack in the threshold cycle drops inc, so the ack wins over abort.
    assign expire = (TIMEOUT != 0) && inc && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: whole-cycle grants, round-robin on ties,
// and an error pulse when the slave stalls past TIMEOUT strobe cycles.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [WB_AW-1:0] m0_adr_i,
    input  logic [WB_DW-1:0] m0_dat_i,
    input  logic             m0_we_i,
    input  logic [WB_SW-1:0] m0_sel_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    output logic [WB_DW-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic [WB_AW-1:0] m1_adr_i,
    input  logic [WB_DW-1:0] m1_dat_i,
    input  logic             m1_we_i,
    input  logic [WB_SW-1:0] m1_sel_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    output logic [WB_DW-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic [WB_AW-1:0] s_adr_o,
    output logic [WB_DW-1:0] s_dat_o,
    output logic             s_we_o,
    output logic [WB_SW-1:0] s_sel_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic [WB_DW-1:0] s_dat_i,
    input  logic             s_ack_i
);

    state_e  state_q, state_d;
    logic    last_q, last_d;
    wb_req_t m0_req, m1_req, s_req;
    logic    tmo_inc, tmo_clr, tmo_expire;

    assign m0_req = '{adr: m0_adr_i, dat: m0_dat_i, we: m0_we_i,
                      sel: m0_sel_i, stb: m0_stb_i, cyc: m0_cyc_i};
    assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i,
                      sel: m1_sel_i, stb: m1_stb_i, cyc: m1_cyc_i};

    // Counter runs only on granted, strobed, un-acked cycles; anything else clears it.
    assign tmo_inc = ((state_q == ST_GNT0 && m0_stb_i) ||
                      (state_q == ST_GNT1 && m1_stb_i)) && !s_ack_i;
    assign tmo_clr = !tmo_inc;

    wb_timeout #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (tmo_clr),
        .inc    (tmo_inc),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_req    = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // last_q == 1 means m1 held the bus most recently, so m0 wins a tie.
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = ST_GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                    last_d  = 1'b1;
                end
            end
            ST_GNT0: begin
                s_req    = m0_req;
                m0_ack_o = s_ack_i;
                if (!m0_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (tmo_expire) begin
                    state_d = ST_ABORT;
                end
            end
            ST_GNT1: begin
                s_req    = m1_req;
                m1_ack_o = s_ack_i;
                if (!m1_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (tmo_expire) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                m0_err_o = !last_q;
                m1_err_o = last_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign s_adr_o  = s_req.adr;
    assign s_dat_o  = s_req.dat;
    assign s_we_o   = s_req.we;
    assign s_sel_o  = s_req.sel;
    assign s_stb_o  = s_req.stb;
    assign s_cyc_o  = s_req.cyc;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with TIMEOUT=4: grants, ties, no preemption,
// timeout abort, ack-at-threshold and asynchronous reset.
module tb_wb_arbiter2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [29:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [31:0] m0_dat_i, m1_dat_i, s_dat_o, s_dat_i, m0_dat_o, m1_dat_o;
    logic        m0_we_i, m1_we_i, s_we_o;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_stb_o, s_cyc_o, s_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter2 #(.TIMEOUT(4), .CW(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic m0_drive(input logic cyc, input logic [29:0] adr, input logic we);
        m0_cyc_i = cyc; m0_stb_i = cyc; m0_adr_i = adr; m0_we_i = we;
        m0_sel_i = 4'hF; m0_dat_i = 32'h0000_1111;
    endtask

    task automatic m1_drive(input logic cyc, input logic [29:0] adr, input logic we,
                            input logic [3:0] sel);
        m1_cyc_i = cyc; m1_stb_i = cyc; m1_adr_i = adr; m1_we_i = we;
        m1_sel_i = sel; m1_dat_i = 32'h0000_2222;
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_cyc"}, 32'(s_cyc_o), 32'd0);
        check({tag, "_stb"}, 32'(s_stb_o), 32'd0);
        check({tag, "_adr"}, 32'(s_adr_o), 32'd0);
        check({tag, "_sel"}, 32'(s_sel_o), 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        m0_drive(1'b0, 30'd0, 1'b0);
        m1_drive(1'b0, 30'd0, 1'b0, 4'h0);
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        check_idle_bus("rst");
        check("rst_acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single master read with two wait states.
        m0_drive(1'b1, 30'h10, 1'b0);
        settle();
        check("single_lat_idle", 32'(s_cyc_o), 32'd0);
        next_cycle(); settle();
        check("single_cyc", 32'(s_cyc_o), 32'd1);
        check("single_adr", 32'(s_adr_o), 32'h10);
        check("single_ws1_ack", 32'(m0_ack_o), 32'd0);
        next_cycle(); settle();
        check("single_ws2_ack", 32'(m0_ack_o), 32'd0);
        next_cycle();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        settle();
        check("single_ack", 32'(m0_ack_o), 32'd1);
        check("single_dat", m0_dat_o, 32'hDEAD_BEEF);
        check("single_m1_ack", 32'(m1_ack_o), 32'd0);
        check("single_m1_dat", m1_dat_o, 32'hDEAD_BEEF);
        next_cycle();
        s_ack_i = 1'b0;
        m0_drive(1'b0, 30'h0, 1'b0);
        settle();
        check("single_release", 32'(s_cyc_o), 32'd0);
        next_cycle();

        // Ties: m0 first after reset, then m1 after one idle cycle, then m0 again.
        do_reset();
        m0_drive(1'b1, 30'h100, 1'b0);
        m1_drive(1'b1, 30'h200, 1'b0, 4'hF);
        s_ack_i = 1'b1;
        settle();
        check("tie_idle", 32'(s_cyc_o), 32'd0);
        next_cycle(); settle();
        check("tie1_adr", 32'(s_adr_o), 32'h100);
        check("tie1_m0_ack", 32'(m0_ack_o), 32'd1);
        check("tie1_m1_ack", 32'(m1_ack_o), 32'd0);
        next_cycle();
        m0_drive(1'b0, 30'h0, 1'b0);
        settle();
        check("tie_m0_rel", 32'(s_cyc_o), 32'd0);
        next_cycle(); settle();
        check("tie_gap_cyc", 32'(s_cyc_o), 32'd0);
        check("tie_gap_m1_ack", 32'(m1_ack_o), 32'd0);
        next_cycle(); settle();
        check("tie2_adr", 32'(s_adr_o), 32'h200);
        check("tie2_m1_ack", 32'(m1_ack_o), 32'd1);
        check("tie2_m0_ack", 32'(m0_ack_o), 32'd0);
        next_cycle();
        m1_drive(1'b0, 30'h0, 1'b0, 4'h0);
        next_cycle();
        m0_drive(1'b1, 30'h100, 1'b0);
        m1_drive(1'b1, 30'h200, 1'b0, 4'hF);
        next_cycle(); settle();
        check("tie3_adr", 32'(s_adr_o), 32'h100);
        check("tie3_m0_ack", 32'(m0_ack_o), 32'd1);
        next_cycle();
        m0_drive(1'b0, 30'h0, 1'b0);
        m1_drive(1'b0, 30'h0, 1'b0, 4'h0);
        next_cycle();

        // No preemption: m1 burst of four writes while m0 waits.
        m1_drive(1'b1, 30'h40, 1'b1, 4'b0011);
        next_cycle();
        m0_drive(1'b1, 30'h80, 1'b0);
        for (int i = 0; i < 4; i++) begin
            m1_adr_i = 30'h40 + 30'(i);
            settle();
            check("np_sel", 32'(s_sel_o), 32'h3);
            check("np_we", 32'(s_we_o), 32'd1);
            check("np_adr", 32'(s_adr_o), 32'h40 + 32'(i));
            check("np_m1_ack", 32'(m1_ack_o), 32'd1);
            check("np_m0_ack", 32'(m0_ack_o), 32'd0);
            next_cycle();
        end
        m1_drive(1'b0, 30'h0, 1'b0, 4'h0);
        settle();
        check("np_rel_cyc", 32'(s_cyc_o), 32'd0);
        check("np_rel_m0_ack", 32'(m0_ack_o), 32'd0);
        next_cycle(); settle();
        check("np_gap_m0_ack", 32'(m0_ack_o), 32'd0);
        next_cycle(); settle();
        check("np_m0_adr", 32'(s_adr_o), 32'h80);
        check("np_m0_we", 32'(s_we_o), 32'd0);
        check("np_m0_ack_late", 32'(m0_ack_o), 32'd1);
        next_cycle();
        m0_drive(1'b0, 30'h0, 1'b0);
        s_ack_i = 1'b0;
        next_cycle();

        // Timeout: strobe visible from cycle t, err exactly at t+4.
        m0_drive(1'b1, 30'h33, 1'b0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            settle();
            check("to_stb", 32'(s_stb_o), 32'd1);
            check("to_no_err", 32'(m0_err_o), 32'd0);
            next_cycle();
        end
        settle();
        check("to_err", 32'(m0_err_o), 32'd1);
        check("to_m1_err", 32'(m1_err_o), 32'd0);
        check("to_abort_cyc", 32'(s_cyc_o), 32'd0);
        check("to_abort_stb", 32'(s_stb_o), 32'd0);
        next_cycle(); settle();
        check("to_err_once", 32'(m0_err_o), 32'd0);
        check("to_idle_cyc", 32'(s_cyc_o), 32'd0);
        next_cycle(); settle();
        check("to_regrant", 32'(s_cyc_o), 32'd1);

        // Ack in the threshold cycle beats the abort; counter restarts on grant.
        for (int i = 0; i < 3; i++) next_cycle();
        s_ack_i = 1'b1;
        settle();
        check("tack_ack", 32'(m0_ack_o), 32'd1);
        check("tack_no_err", 32'(m0_err_o), 32'd0);
        next_cycle();
        s_ack_i = 1'b0;
        settle();
        check("tack_still_gnt", 32'(s_cyc_o), 32'd1);
        check("tack_no_err2", 32'(m0_err_o), 32'd0);
        next_cycle();
        m0_drive(1'b0, 30'h0, 1'b0);
        next_cycle();

        // Asynchronous reset while GNT1 is active.
        m1_drive(1'b1, 30'h55, 1'b0, 4'hF);
        s_ack_i = 1'b1;
        next_cycle(); settle();
        check("ar_gnt1_cyc", 32'(s_cyc_o), 32'd1);
        check("ar_gnt1_ack", 32'(m1_ack_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        check("ar_cyc_drop", 32'(s_cyc_o), 32'd0);
        check("ar_stb_drop", 32'(s_stb_o), 32'd0);
        check("ar_ack_drop", 32'(m1_ack_o), 32'd0);
        #1 rst_i = 1'b0;
        m0_drive(1'b1, 30'h66, 1'b0);
        next_cycle(); settle();
        check("ar_tie_adr", 32'(s_adr_o), 32'h66);
        check("ar_tie_m0_ack", 32'(m0_ack_o), 32'd1);
        check("ar_tie_m1_ack", 32'(m1_ack_o), 32'd0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
